// File: rtl/mac_feeder_pkg.sv
// Shared types and constants for the MAC array feeder: FSM states, default
// geometry and the weight-column enable masks.
package mac_feeder_pkg;

  localparam int PIPE_LAT_DEF = 8;
  localparam int LEN_W_DEF    = 8;

  localparam logic [3:0] MASK_1COL = 4'b1000;
  localparam logic [3:0] MASK_2COL = 4'b1100;
  localparam logic [3:0] MASK_3COL = 4'b1110;
  localparam logic [3:0] MASK_4COL = 4'b1111;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_W,
    STREAM,
    DRAIN,
    DONE
  } state_t;

  // Out-of-range column counts fall back to the full array.
  function automatic logic [3:0] cols_to_mask(input logic [2:0] cols);
    case (cols)
      3'd1:    return MASK_1COL;
      3'd2:    return MASK_2COL;
      3'd3:    return MASK_3COL;
      default: return MASK_4COL;
    endcase
  endfunction

endpackage

// File: rtl/mac_valid_delay.sv
// Fixed-depth shift register carrying {valid, addr} alongside the MAC array
// pipeline so each RESULT can be tagged with the vector index that produced it.
module mac_valid_delay #(
  parameter int DEPTH = 8,
  parameter int AW    = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          out_valid,
  output logic [AW-1:0] out_addr,
  output logic          any_valid
);

  logic [DEPTH-1:0] vld_q;
  logic [AW-1:0]    addr_q [DEPTH];

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) addr_q[i] <= '0;
    end else begin
      vld_q[0]  <= in_valid;
      // Address is zeroed on empty slots so res_addr idles at 0.
      addr_q[0] <= in_valid ? in_addr : '0;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[DEPTH-1];
  assign out_addr  = addr_q[DEPTH-1];
  assign any_valid = |vld_q;

endmodule

// File: rtl/mac_array_feeder.sv
// Sequences one MAC-array job: loads four weight words, streams cfg_len input
// vectors (optionally with stored partial sums) and writes back tagged results.
module mac_array_feeder
  import mac_feeder_pkg::*;
#(
  parameter int PIPE_LAT = PIPE_LAT_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               start,
  input  logic [2:0]         cfg_cols,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_accum,
  output logic               busy,
  output logic               done,
  input  logic [31:0]        w_data,
  input  logic               w_valid,
  output logic               w_ready,
  input  logic [31:0]        x_data,
  input  logic               x_valid,
  output logic               x_ready,
  output logic               psum_rd_en,
  output logic [LEN_W-1:0]   psum_rd_addr,
  input  logic [127:0]       psum_rd_data,
  output logic [31:0]        mac_x_o,
  output logic [31:0]        mac_w_o,
  output logic               mac_en_x_o,
  output logic [3:0]         mac_en_w_o,
  output logic               mac_stop_o,
  output logic               mac_used_row_o,
  output logic               mac_overwrite_o,
  output logic [127:0]       mac_psum_o,
  input  logic [127:0]       res_i,
  output logic               res_valid,
  output logic [LEN_W-1:0]   res_addr,
  output logic [127:0]       res_data,
  output state_t             dbg_state
);

  // Handshake: a beat transfers on a cycle where valid && ready are both high;
  // ready never depends on valid, and valid/data are sampled only on transfer.

  state_t           state_q, state_d;
  logic [3:0]       mask_q;
  logic [LEN_W-1:0] len_q;
  logic             accum_q;
  logic [1:0]       wcnt_q;
  logic [LEN_W-1:0] issued_q;
  logic [LEN_W-1:0] x_addr_q;
  logic             w_fire, x_fire, last_x, line_busy;

  assign w_ready = (state_q == LOAD_W);
  assign w_fire  = w_valid & w_ready;
  assign x_ready = (state_q == STREAM) && (issued_q < len_q);
  assign x_fire  = x_valid & x_ready;
  assign last_x  = x_fire && (issued_q == len_q - LEN_W'(1));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD_W;
      LOAD_W:  if (w_fire && wcnt_q == 2'd3) state_d = (len_q == '0) ? DRAIN : STREAM;
      STREAM:  if (last_x) state_d = DRAIN;
      // The registered issue stage feeds the delay line, so it must be empty too.
      DRAIN:   if (!mac_en_x_o && !line_busy) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mask_q     <= '0;
      len_q      <= '0;
      accum_q    <= 1'b0;
      wcnt_q     <= '0;
      issued_q   <= '0;
      x_addr_q   <= '0;
      mac_w_o    <= '0;
      mac_en_w_o <= '0;
      mac_x_o    <= '0;
      mac_en_x_o <= 1'b0;
    end else begin
      if (state_q == IDLE && start) begin
        mask_q   <= cols_to_mask(cfg_cols);
        len_q    <= cfg_len;
        accum_q  <= cfg_accum;
        wcnt_q   <= '0;
        issued_q <= '0;
      end
      if (w_fire) wcnt_q <= wcnt_q + 2'd1;
      if (x_fire && issued_q != len_q) issued_q <= issued_q + LEN_W'(1);
      mac_w_o    <= w_fire ? w_data : '0;
      mac_en_w_o <= w_fire ? mask_q : 4'b0000;
      mac_x_o    <= x_fire ? x_data : '0;
      mac_en_x_o <= x_fire;
      x_addr_q   <= x_fire ? issued_q : '0;
    end
  end

  // Partial-sum read is issued with the accept; its data lines up with mac_en_x_o.
  assign psum_rd_en      = x_fire & accum_q;
  assign psum_rd_addr    = psum_rd_en ? issued_q : '0;
  assign mac_psum_o      = (mac_en_x_o && accum_q) ? psum_rd_data : '0;
  assign mac_overwrite_o = mac_en_x_o & accum_q;

  mac_valid_delay #(
    .DEPTH (PIPE_LAT),
    .AW    (LEN_W)
  ) u_delay (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (mac_en_x_o),
    .in_addr   (x_addr_q),
    .out_valid (res_valid),
    .out_addr  (res_addr),
    .any_valid (line_busy)
  );

  assign res_data       = res_valid ? res_i : '0;
  assign busy           = (state_q != IDLE);
  assign mac_used_row_o = busy;
  assign mac_stop_o     = (state_q == IDLE) || (state_q == DONE);
  assign done           = (state_q == DONE);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_mac_array_feeder.sv
// Randomized bench for mac_array_feeder: a job-level model predicts weight
// beats, issued vectors and tagged results, and scenario tasks compare them.
module tb_mac_array_feeder;
  import mac_feeder_pkg::*;

  localparam int PL = 8;
  localparam int LW = 8;
  localparam int WREC = 68;   // {cycle, mask, w}
  localparam int XREC = 193;  // {cycle, x, psum, overwrite}
  localparam int RREC = 168;  // {cycle, addr, data}

  logic          CLK = 1'b0;
  logic          RST;
  logic          start;
  logic [2:0]    cfg_cols;
  logic [LW-1:0] cfg_len;
  logic          cfg_accum;
  logic          busy, done;
  logic [31:0]   w_data;
  logic          w_valid, w_ready;
  logic [31:0]   x_data;
  logic          x_valid, x_ready;
  logic          psum_rd_en;
  logic [LW-1:0] psum_rd_addr;
  logic [127:0]  psum_rd_data;
  logic [31:0]   mac_x_o, mac_w_o;
  logic          mac_en_x_o;
  logic [3:0]    mac_en_w_o;
  logic          mac_stop_o, mac_used_row_o, mac_overwrite_o;
  logic [127:0]  mac_psum_o, res_i, res_data;
  logic          res_valid;
  logic [LW-1:0] res_addr;
  state_t        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int done_cnt, done_cyc, last_res_cyc, bubble_err;

  logic [WREC-1:0] exp_w_q[$], got_w_q[$];
  logic [XREC-1:0] exp_x_q[$], got_x_q[$];
  logic [RREC-1:0] exp_res_q[$], got_res_q[$];

  mac_array_feeder #(.PIPE_LAT(PL), .LEN_W(LW)) dut (
    .CLK(CLK), .RST(RST), .start(start), .cfg_cols(cfg_cols), .cfg_len(cfg_len),
    .cfg_accum(cfg_accum), .busy(busy), .done(done),
    .w_data(w_data), .w_valid(w_valid), .w_ready(w_ready),
    .x_data(x_data), .x_valid(x_valid), .x_ready(x_ready),
    .psum_rd_en(psum_rd_en), .psum_rd_addr(psum_rd_addr), .psum_rd_data(psum_rd_data),
    .mac_x_o(mac_x_o), .mac_w_o(mac_w_o), .mac_en_x_o(mac_en_x_o), .mac_en_w_o(mac_en_w_o),
    .mac_stop_o(mac_stop_o), .mac_used_row_o(mac_used_row_o),
    .mac_overwrite_o(mac_overwrite_o), .mac_psum_o(mac_psum_o),
    .res_i(res_i), .res_valid(res_valid), .res_addr(res_addr), .res_data(res_data),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / environment ----------------
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  function automatic logic [127:0] res_fn(input int c);
    logic [31:0] u;
    u = 32'(c);
    return {u, u ^ 32'hFFFF0000, u * 32'd7, 32'hA5A50000 + u};
  endfunction

  assign res_i = res_fn(cyc);

  // Partial-sum memory: one-cycle read latency, garbage when not read.
  always @(posedge CLK)
    psum_rd_data <= psum_rd_en ? (128'(psum_rd_addr) << 4) : {4{32'hDEADBEEF}};

  // ---------------- monitor ----------------
  always @(negedge CLK) begin
    if (mac_en_w_o != 4'b0000) got_w_q.push_back({32'(cyc), mac_en_w_o, mac_w_o});
    if (mac_en_x_o) got_x_q.push_back({32'(cyc), mac_x_o, mac_psum_o, mac_overwrite_o});
    else if (mac_x_o !== 32'h0 || mac_psum_o !== 128'h0 || mac_overwrite_o !== 1'b0) bubble_err++;
    if (res_valid) begin
      got_res_q.push_back({32'(cyc), res_addr, res_data});
      last_res_cyc = cyc;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- driver / model ----------------
  task automatic run_job(input logic [2:0] cols, input int len, input bit accum,
                         input int w_gap, input int x_gap, input int hole_k,
                         input bit wait_done);
    logic [3:0] mask;
    int n, beats, k, holes;
    n    = (cols >= 3'd1 && cols <= 3'd4) ? int'(cols) : 4;
    mask = 4'(4'b1111 << (4 - n));
    exp_w_q.delete(); got_w_q.delete(); exp_x_q.delete(); got_x_q.delete();
    exp_res_q.delete(); got_res_q.delete();
    done_cnt = 0; done_cyc = 0; last_res_cyc = 0; bubble_err = 0;
    start = 1'b1; cfg_cols = cols; cfg_len = LW'(len); cfg_accum = accum;
    w_valid = 1'b0; x_valid = 1'($urandom_range(1)); x_data = $urandom;
    @(posedge CLK); #1;
    start = 1'b0;
    beats = 0;
    while (beats < 4) begin
      cfg_cols = 3'($urandom); cfg_len = LW'($urandom); cfg_accum = 1'($urandom);
      start   = ($urandom_range(3) == 0);
      w_valid = ($urandom_range(99) >= w_gap);
      w_data  = $urandom;
      x_valid = 1'($urandom_range(1)); x_data = $urandom;
      if (w_valid) begin
        exp_w_q.push_back({32'(cyc + 1), mask, w_data});
        beats++;
      end
      @(posedge CLK); #1;
    end
    k = 0; holes = 0;
    while (k < len) begin
      start   = ($urandom_range(3) == 0);
      w_valid = 1'($urandom_range(1)); w_data = $urandom;
      x_data  = $urandom;
      if (k == hole_k && holes < 2) begin
        x_valid = 1'b0;
        holes++;
      end else begin
        x_valid = ($urandom_range(99) >= x_gap);
      end
      if (x_valid) begin
        exp_x_q.push_back({32'(cyc + 1), x_data, accum ? (128'(k) << 4) : 128'h0, accum});
        exp_res_q.push_back({32'(cyc + 1 + PL), 8'(k), res_fn(cyc + 1 + PL)});
        k++;
      end
      @(posedge CLK); #1;
    end
    start = 1'b0;
    if (wait_done) begin
      for (int i = 0; i < PL + 40 && done_cnt == 0; i++) begin
        x_valid = 1'($urandom_range(1)); w_valid = 1'($urandom_range(1));
        @(posedge CLK); #1;
      end
      x_valid = 1'b0; w_valid = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
    end else begin
      x_valid = 1'b0; w_valid = 1'b0;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    n_checks++;
    if ({busy, done, w_ready, x_ready, psum_rd_en, mac_en_x_o, mac_en_w_o, res_valid, mac_used_row_o} !== 12'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b required all zero",
               {busy, done, w_ready, x_ready, psum_rd_en, mac_en_x_o, mac_en_w_o, res_valid, mac_used_row_o});
    end
    n_checks++;
    if (mac_stop_o !== 1'b1) begin n_fail++; $display("FAIL reset_stop: got %b required 1", mac_stop_o); end
    n_checks++;
    if ({mac_x_o, mac_w_o, mac_psum_o, res_data, res_addr, psum_rd_addr, mac_overwrite_o} !== '0) begin
      n_fail++; $display("FAIL reset_data: data outputs not zero during reset");
    end
    n_checks++;
    if (dbg_state !== IDLE) begin n_fail++; $display("FAIL reset_state: got %0d required %0d", dbg_state, IDLE); end
    RST = 1'b0;
    @(posedge CLK); #1;
  endtask

  task automatic test_basic();
    run_job(3'd4, 3, 1'b0, 0, 0, -1, 1'b1);
    n_checks++;
    if (got_w_q.size() != 4) begin n_fail++; $display("FAIL basic_w_count: got %0d required 4", got_w_q.size()); end
    for (int i = 0; i < 4 && i < got_w_q.size(); i++) begin
      n_checks++;
      if (got_w_q[i] !== exp_w_q[i]) begin n_fail++; $display("FAIL basic_w[%0d]: got %h required %h", i, got_w_q[i], exp_w_q[i]); end
    end
    n_checks++;
    if (got_res_q.size() != 3) begin n_fail++; $display("FAIL basic_res_count: got %0d required 3", got_res_q.size()); end
    for (int i = 0; i < 3 && i < got_res_q.size(); i++) begin
      n_checks++;
      if (got_res_q[i] !== exp_res_q[i]) begin n_fail++; $display("FAIL basic_res[%0d]: got %h required %h", i, got_res_q[i], exp_res_q[i]); end
    end
    n_checks++;
    if (done_cnt != 1 || done_cyc <= last_res_cyc) begin
      n_fail++; $display("FAIL basic_done: got count %0d at %0d (last res %0d) required one pulse after results", done_cnt, done_cyc, last_res_cyc);
    end
    n_checks++;
    if (busy !== 1'b0 || mac_stop_o !== 1'b1) begin n_fail++; $display("FAIL basic_idle: got busy %b stop %b required 0 1", busy, mac_stop_o); end
  endtask

  task automatic test_accum();
    run_job(3'd3, 3, 1'b1, 0, 0, -1, 1'b1);
    n_checks++;
    if (got_x_q.size() != 3) begin n_fail++; $display("FAIL accum_x_count: got %0d required 3", got_x_q.size()); end
    for (int i = 0; i < 3 && i < got_x_q.size(); i++) begin
      n_checks++;
      if (got_x_q[i] !== exp_x_q[i]) begin n_fail++; $display("FAIL accum_x[%0d]: got %h required %h", i, got_x_q[i], exp_x_q[i]); end
    end
    n_checks++;
    if (got_w_q.size() != 4 || got_w_q[0] !== exp_w_q[0]) begin n_fail++; $display("FAIL accum_mask3: got %0d beats, first %h required %h", got_w_q.size(), got_w_q.size() ? got_w_q[0] : '0, exp_w_q[0]); end
    n_checks++;
    if (done_cnt != 1) begin n_fail++; $display("FAIL accum_done: got %0d required 1", done_cnt); end
  endtask

  task automatic test_bubbles();
    run_job(3'd4, 4, 1'b0, 0, 0, 2, 1'b1);
    n_checks++;
    if (got_res_q.size() != 4) begin n_fail++; $display("FAIL bubble_res_count: got %0d required 4", got_res_q.size()); end
    for (int i = 0; i < 4 && i < got_res_q.size(); i++) begin
      n_checks++;
      if (got_res_q[i] !== exp_res_q[i]) begin n_fail++; $display("FAIL bubble_res[%0d]: got %h required %h", i, got_res_q[i], exp_res_q[i]); end
    end
    n_checks++;
    if (bubble_err != 0) begin n_fail++; $display("FAIL bubble_idle_drive: got %0d nonzero idle cycles required 0", bubble_err); end
  endtask

  task automatic test_masks();
    logic [2:0] cols_tab [3] = '{3'd0, 3'd2, 3'd1};
    for (int t = 0; t < 3; t++) begin
      run_job(cols_tab[t], 0, 1'b0, 40, 0, -1, 1'b1);
      n_checks++;
      if (got_w_q.size() != 4) begin n_fail++; $display("FAIL mask_count cols=%0d: got %0d required 4", cols_tab[t], got_w_q.size()); end
      for (int i = 0; i < 4 && i < got_w_q.size(); i++) begin
        n_checks++;
        if (got_w_q[i] !== exp_w_q[i]) begin n_fail++; $display("FAIL mask_w cols=%0d [%0d]: got %h required %h", cols_tab[t], i, got_w_q[i], exp_w_q[i]); end
      end
      n_checks++;
      if (got_res_q.size() != 0 || got_x_q.size() != 0 || done_cnt != 1) begin
        n_fail++; $display("FAIL len0: got res %0d x %0d done %0d required 0 0 1", got_res_q.size(), got_x_q.size(), done_cnt);
      end
    end
  endtask

  task automatic test_random(input int jobs, input int max_len);
    for (int j = 0; j < jobs; j++) begin
      run_job(3'($urandom), $urandom_range(max_len, 1), 1'($urandom), 30, 30, -1, 1'b1);
      n_checks++;
      if (got_w_q.size() != exp_w_q.size() || got_x_q.size() != exp_x_q.size() || got_res_q.size() != exp_res_q.size()) begin
        n_fail++; $display("FAIL rand_counts job %0d: got w%0d x%0d r%0d required w%0d x%0d r%0d", j,
                           got_w_q.size(), got_x_q.size(), got_res_q.size(), exp_w_q.size(), exp_x_q.size(), exp_res_q.size());
      end
      for (int i = 0; i < exp_w_q.size() && i < got_w_q.size(); i++) begin
        n_checks++;
        if (got_w_q[i] !== exp_w_q[i]) begin n_fail++; $display("FAIL rand_w job %0d [%0d]: got %h required %h", j, i, got_w_q[i], exp_w_q[i]); end
      end
      for (int i = 0; i < exp_x_q.size() && i < got_x_q.size(); i++) begin
        n_checks++;
        if (got_x_q[i] !== exp_x_q[i]) begin n_fail++; $display("FAIL rand_x job %0d [%0d]: got %h required %h", j, i, got_x_q[i], exp_x_q[i]); end
      end
      for (int i = 0; i < exp_res_q.size() && i < got_res_q.size(); i++) begin
        n_checks++;
        if (got_res_q[i] !== exp_res_q[i]) begin n_fail++; $display("FAIL rand_res job %0d [%0d]: got %h required %h", j, i, got_res_q[i], exp_res_q[i]); end
      end
      n_checks++;
      if (done_cnt != 1 || bubble_err != 0) begin n_fail++; $display("FAIL rand_done job %0d: got done %0d idle-drive %0d required 1 0", j, done_cnt, bubble_err); end
    end
  endtask

  task automatic test_reset_drain();
    int n_before;
    run_job(3'd4, 5, 1'b1, 0, 0, -1, 1'b0);
    @(posedge CLK); #2;
    RST = 1'b1;
    #1;
    n_before = got_res_q.size();
    n_checks++;
    if ({busy, done, res_valid, mac_en_x_o, psum_rd_en, mac_used_row_o} !== 6'b0 || mac_stop_o !== 1'b1) begin
      n_fail++; $display("FAIL drain_reset_outputs: got %b stop %b required 000000 1",
                         {busy, done, res_valid, mac_en_x_o, psum_rd_en, mac_used_row_o}, mac_stop_o);
    end
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    repeat (PL + 6) @(posedge CLK);
    #1;
    n_checks++;
    if (got_res_q.size() != n_before || done_cnt != 0) begin
      n_fail++; $display("FAIL drain_abort: got %0d extra results %0d done pulses required 0 0", got_res_q.size() - n_before, done_cnt);
    end
    run_job(3'd2, 3, 1'b0, 0, 0, -1, 1'b1);
    n_checks++;
    if (got_res_q.size() != 3 || done_cnt != 1) begin n_fail++; $display("FAIL drain_restart: got %0d results %0d done required 3 1", got_res_q.size(), done_cnt); end
    for (int i = 0; i < 3 && i < got_res_q.size(); i++) begin
      n_checks++;
      if (got_res_q[i] !== exp_res_q[i]) begin n_fail++; $display("FAIL drain_restart_res[%0d]: got %h required %h", i, got_res_q[i], exp_res_q[i]); end
    end
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST = 1'b1; start = 1'b0; cfg_cols = '0; cfg_len = '0; cfg_accum = 1'b0;
    w_data = '0; w_valid = 1'b0; x_data = '0; x_valid = 1'b0;
    done_cnt = 0; done_cyc = 0; last_res_cyc = 0; bubble_err = 0;
    repeat (3) @(posedge CLK);
    #1;
    test_reset();
    test_basic();
    test_accum();
    test_bubbles();
    test_masks();
    test_random(6, 20);
    test_random(1, 255);
    run_job(3'd4, 255, 1'b1, 5, 5, -1, 1'b1);
    n_checks++;
    if (got_res_q.size() != 255 || got_x_q.size() != 255 || done_cnt != 1) begin
      n_fail++; $display("FAIL max_len: got res %0d x %0d done %0d required 255 255 1", got_res_q.size(), got_x_q.size(), done_cnt);
    end
    for (int i = 0; i < 255 && i < got_res_q.size(); i++) begin
      n_checks++;
      if (got_res_q[i] !== exp_res_q[i]) begin n_fail++; $display("FAIL max_len_res[%0d]: got %h required %h", i, got_res_q[i], exp_res_q[i]); end
    end
    test_reset_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_array_feeder.md
MAC_ARRAY_FEEDER -- requirements
Module: mac_array_feeder

Interface
REQ-001 Parameter PIPE_LAT, default 8: cycles from a word on mac_x_o until its RESULT appears on res_i.
REQ-002 Parameter LEN_W, default 8: width of the vector count and the address fields.
REQ-003 CLK  in  1  single clock; all logic on the rising edge.
REQ-004 RST  in  1  asynchronous, active-high reset.
REQ-005 start  in  1  one-cycle job start pulse.
REQ-006 cfg_cols  in  3  active weight columns, 1..4.
REQ-007 cfg_len  in  LEN_W  input vectors in the job.
REQ-008 cfg_accum  in  1  1 = add stored partial sums.
REQ-009 busy  out  1  job in progress.
REQ-010 done  out  1  one-cycle pulse at job end.
REQ-011 w_data  in  32, w_valid  in  1, w_ready  out  1  weight stream, four int8 per word.
REQ-012 x_data  in  32, x_valid  in  1, x_ready  out  1  input-feature stream, four uint8 per word.
REQ-013 psum_rd_en  out  1, psum_rd_addr  out  LEN_W, psum_rd_data  in  128  partial-sum buffer read port; data arrives 1 cycle after the request.
REQ-014 mac_x_o  out  32, mac_w_o  out  32, mac_en_x_o  out  1, mac_en_w_o  out  4, mac_stop_o  out  1, mac_used_row_o  out  1, mac_overwrite_o  out  1, mac_psum_o  out  128  array drive.
REQ-015 res_i  in  128  array RESULT.
REQ-016 res_valid  out  1, res_addr  out  LEN_W, res_data  out  128  result writeback; there is no backpressure.

Function
REQ-017 The FSM SHALL have the states IDLE, LOAD_W, STREAM, DRAIN and DONE.
REQ-018 IDLE -> LOAD_W on start; the block SHALL latch cfg_* at start; start in any other state SHALL be ignored.
REQ-019 The weight mask SHALL be: cfg_cols 1=4'b1000, 2=4'b1100, 3=4'b1110, 4=4'b1111; cfg_cols 0 or >4 SHALL be treated as 4.
REQ-020 LOAD_W: w_ready=1; each w_valid&w_ready beat SHALL drive mac_w_o=w_data and mac_en_w_o=mask on the next cycle (1-cycle registered).
REQ-021 LOAD_W SHALL end after exactly 4 beats; w_valid low SHALL stall LOAD_W with mac_en_w_o=0.
REQ-022 LOAD_W -> STREAM after 4 beats; LOAD_W -> DRAIN if cfg_len=0.
REQ-023 STREAM: x_ready=1 while the issued count < cfg_len.
REQ-024 On an accept in cycle t (index k, 0-based), psum_rd_en SHALL be 1 and psum_rd_addr=k in cycle t, but only when cfg_accum=1.
REQ-025 In cycle t+1 the block SHALL drive mac_x_o=x_data(t), mac_en_x_o=1, mac_psum_o=psum_rd_data, and mac_overwrite_o=cfg_accum.
REQ-026 When cfg_accum=0, mac_psum_o SHALL be 0.
REQ-027 A bubble (x_valid=0) SHALL drive mac_en_x_o=0 and mac_x_o=0 in the next cycle; it SHALL produce no res_valid.
REQ-028 STREAM -> DRAIN in the cycle the cfg_len-th word is accepted.
REQ-029 A PIPE_LAT-deep delay line SHALL carry {valid,k}; res_valid=1, res_addr=k and res_data=res_i exactly PIPE_LAT cycles after the mac_en_x_o=1 cycle for k.
REQ-030 DRAIN -> DONE when the delay line holds no valid entry; DONE SHALL assert done for 1 cycle and return to IDLE.
REQ-031 mac_stop_o SHALL be 1 in IDLE and DONE and 0 otherwise.
REQ-032 mac_used_row_o SHALL be 1 while busy.
REQ-033 busy SHALL be 1 in every state except IDLE.
REQ-034 The issued count SHALL saturate at cfg_len and never wrap.
REQ-035 cfg_len=2^LEN_W-1 SHALL be legal.
REQ-036 Simultaneous last accept and a res_valid output SHALL both be honoured in the same cycle.

Reset
REQ-037 On RST: state=IDLE, and all counters and the delay line SHALL clear.
REQ-038 On RST: every output SHALL be 0, except mac_stop_o=1.
REQ-039 RST mid-job SHALL abort the job with no done pulse and no further res_valid.

Structure
REQ-040 Package mac_feeder_pkg SHALL hold the state enum, PIPE_LAT default, LEN_W default, and the mask encodings.
REQ-041 Sub-module mac_valid_delay SHALL implement the parameterised {valid,addr} shift register.

Verification
REQ-042 cfg_cols=4, cfg_len=3, cfg_accum=0, continuous streams -> mac_en_w_o=1111 for 4 cycles; res_valid at addr 0,1,2 on consecutive cycles, PIPE_LAT cycles after each issue; one done pulse.
REQ-043 cfg_accum=1, psum_rd_data=addr*0x10 -> mac_psum_o equals 0x00,0x10,0x20 aligned with mac_en_x_o; mac_overwrite_o=1.
REQ-044 x_valid low for 2 cycles mid-stream, cfg_len=4 -> exactly 4 res_valid with addrs 0..3 and a 2-cycle gap.
REQ-045 cfg_cols=0 -> mask 1111; cfg_cols=2 -> mask 1100; cfg_len=0 -> done after LOAD_W with no res_valid.
REQ-046 RST pulsed during DRAIN -> outputs at reset values immediately, no done, and the next start runs normally.
